multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mc_pkg.sv | 50 +++++
 rtl/mc_opdec.sv | 30 +++
 rtl/multicycle_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared types for the multicycle controller: FSM states, instruction classes,
// opcode constants and the datapath select encodings.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTEXEC,
        S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_JAL
    } state_t;

    typedef enum logic [2:0] {
        IC_NONE, IC_LOAD, IC_STORE, IC_RTYPE, IC_BRANCH, IC_ADDI, IC_JUMP, IC_JAL
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] SRCB_B = 2'b00, SRCB_4 = 2'b01, SRCB_SIMM = 2'b10, SRCB_SIMM_SL2 = 2'b11;
    localparam logic [1:0] ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10;
    localparam logic [1:0] REGDST_RT = 2'b00, REGDST_RD = 2'b01, REGDST_R31 = 2'b10;
    localparam logic [1:0] M2R_ALUOUT = 2'b00, M2R_MEM = 2'b01, M2R_PC = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       bne;
        logic       regwrite;
        logic       alusrca;
        logic       lb;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       done;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_opdec.sv
// Opcode classifier: maps op to an instruction class and a legal flag,
// with JAL and LB support selectable at elaboration.
module mc_opdec
    import mc_pkg::*;
#(
    parameter bit HAS_JAL = 1'b1,
    parameter bit HAS_LB  = 1'b1
) (
    input  logic [5:0] op,
    output iclass_t    iclass,
    output logic       legal
);

    always_comb begin
        iclass = IC_NONE;
        case (op)
            OP_LW:          iclass = IC_LOAD;
            OP_LB:          iclass = HAS_LB ? IC_LOAD : IC_NONE;
            OP_SW:          iclass = IC_STORE;
            OP_RTYPE:       iclass = IC_RTYPE;
            OP_BEQ, OP_BNE: iclass = IC_BRANCH;
            OP_ADDI:        iclass = IC_ADDI;
            OP_J:           iclass = IC_JUMP;
            OP_JAL:         iclass = HAS_JAL ? IC_JAL : IC_NONE;
            default:        iclass = IC_NONE;
        endcase
        legal = (iclass != IC_NONE);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM; Moore outputs except for the mem_ready
// qualified fetch strobes, store completion and memory-state exits.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter bit HAS_JAL = 1'b1,
    parameter bit HAS_LB  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       bne,
    output logic       regwrite,
    output logic       alusrca,
    output logic       lb,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic       done,
    output logic       illegal
);

    state_t  state_q, state_d;
    iclass_t iclass;
    logic    legal;
    ctrl_t   ctrl, ctrl_o;

    mc_opdec #(.HAS_JAL(HAS_JAL), .HAS_LB(HAS_LB)) u_opdec (
        .op     (op),
        .iclass (iclass),
        .legal  (legal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.alusrcb = SRCB_4;
                ctrl.irwrite = mem_ready;
                ctrl.pcwrite = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_SIMM_SL2;
                if (!legal) begin
                    ctrl.illegal = 1'b1;
                    ctrl.done    = 1'b1;
                    state_d      = S_FETCH;
                end else begin
                    case (iclass)
                        IC_LOAD, IC_STORE: state_d = S_MEMADR;
                        IC_RTYPE:          state_d = S_RTEXEC;
                        IC_BRANCH:         state_d = S_BRANCH;
                        IC_ADDI:           state_d = S_ADDIEX;
                        IC_JUMP:           state_d = S_JUMP;
                        IC_JAL:            state_d = S_JAL;
                        default:           state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_SIMM;
                state_d      = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = M2R_MEM;
                ctrl.lb       = (op == OP_LB);
                ctrl.done     = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWR: begin
                // the store retires in the cycle its handshake completes
                ctrl.mem_req  = 1'b1;
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
                ctrl.done     = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_RTEXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
                state_d      = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = REGDST_RD;
                ctrl.done     = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                ctrl.branch  = (op == OP_BEQ);
                ctrl.bne     = (op == OP_BNE);
                ctrl.done    = 1'b1;
                state_d      = S_FETCH;
            end
            S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_SIMM;
                state_d      = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.done     = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pcsrc   = PCSRC_JUMP;
                ctrl.pcwrite = 1'b1;
                ctrl.done    = 1'b1;
                state_d      = S_FETCH;
            end
            S_JAL: begin
                ctrl.pcsrc    = PCSRC_JUMP;
                ctrl.pcwrite  = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = REGDST_R31;
                ctrl.memtoreg = M2R_PC;
                ctrl.done     = 1'b1;
                state_d       = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset must silence outputs immediately, not just at the next edge.
    assign ctrl_o = reset ? '0 : ctrl;

    assign mem_req  = ctrl_o.mem_req;
    assign iord     = ctrl_o.iord;
    assign memwrite = ctrl_o.memwrite;
    assign irwrite  = ctrl_o.irwrite;
    assign pcwrite  = ctrl_o.pcwrite;
    assign branch   = ctrl_o.branch;
    assign bne      = ctrl_o.bne;
    assign regwrite = ctrl_o.regwrite;
    assign alusrca  = ctrl_o.alusrca;
    assign lb       = ctrl_o.lb;
    assign alusrcb  = ctrl_o.alusrcb;
    assign aluop    = ctrl_o.aluop;
    assign pcsrc    = ctrl_o.pcsrc;
    assign regdst   = ctrl_o.regdst;
    assign memtoreg = ctrl_o.memtoreg;
    assign done     = ctrl_o.done;
    assign illegal  = ctrl_o.illegal;

endmodule
